// File: rtl/systolic_feeder4_if.sv
// Beat stream into the 4x4 systolic feeder: job start, A column / B row per beat.
// Latency: none (signal bundle only).
// Backpressure: in_ready from the feeder gates every beat; start is a bare pulse.
// Ports: start, in_valid, in_last, in_a, in_b (producer -> feeder), in_ready (feeder -> producer).
interface systolic_feeder4_if #(
    parameter int DW = 16
);
    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic            in_last;
    logic [4*DW-1:0] in_a;
    logic [4*DW-1:0] in_b;

    modport master (
        output start, in_valid, in_last, in_a, in_b,
        input  in_ready
    );

    modport slave (
        input  start, in_valid, in_last, in_a, in_b,
        output in_ready
    );
endinterface

// File: rtl/systolic_feeder4.sv
// Skews A columns / B rows onto the 4x4 systolic array edges, plus clear and done pulses.
// Latency: a beat accepted in cycle t reaches lane i (a(i+1)/b(i+1)) in cycle t+1+i.
// Backpressure: in_ready is a pure FEED-state decode; stalls shift zero bubbles into all lanes.
// Ports: clk, rst (async active-high), feed (slave side of systolic_feeder4_if),
//        a1..a4 / b1..b4 array edge streams, arr_clr, busy, done, beat_cnt, stall_cnt.
// Option: define FEEDER_STALL_CNT_EN to build the FEED stall counter; otherwise stall_cnt is 0.
module systolic_feeder4 #(
    parameter int DW    = 16,
    parameter int DRAIN = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    systolic_feeder4_if.slave     feed,
    output logic [DW-1:0]         a1,
    output logic [DW-1:0]         a2,
    output logic [DW-1:0]         a3,
    output logic [DW-1:0]         a4,
    output logic [DW-1:0]         b1,
    output logic [DW-1:0]         b2,
    output logic [DW-1:0]         b3,
    output logic [DW-1:0]         b4,
    output logic                  arr_clr,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            beat_cnt,
    output logic [15:0]           stall_cnt
);
    localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state, state_n;
    logic [DCW-1:0] drain_cnt;
    logic           accept;
    logic [DW-1:0]  a_out [4];
    logic [DW-1:0]  b_out [4];

    assign accept = (state == S_FEED) && feed.in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        feed.in_ready = 1'b0;
        arr_clr       = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (feed.start) begin
                    state_n = S_CLEAR;
                end
            end
            S_CLEAR: begin
                arr_clr = 1'b1;
                state_n = S_FEED;
            end
            S_FEED: begin
                feed.in_ready = 1'b1;
                if (feed.in_valid && feed.in_last) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_n = S_IDLE;
            end
        endcase
    end

    // Loaded with DRAIN-1 on the last accept so DRAIN occupies exactly DRAIN cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if (accept && feed.in_last) begin
            drain_cnt <= DCW'(DRAIN - 1);
        end else if (state == S_DRAIN && drain_cnt != '0) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (state == S_CLEAR) begin
            beat_cnt <= '0;
        end else if (accept && beat_cnt != 8'hFF) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

`ifdef FEEDER_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == S_CLEAR) begin
            stall_cnt <= '0;
        end else if (state == S_FEED && !feed.in_valid && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

    // Lane i is i+1 registers deep; anything but an accepted beat enters as zero,
    // so bubbles and idle cycles add nothing to the accumulators.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [DW-1:0] dla [0:i];
        logic [DW-1:0] dlb [0:i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= i; j++) begin
                    dla[j] <= '0;
                    dlb[j] <= '0;
                end
            end else begin
                dla[0] <= accept ? feed.in_a[i*DW +: DW] : '0;
                dlb[0] <= accept ? feed.in_b[i*DW +: DW] : '0;
                for (int j = 1; j <= i; j++) begin
                    dla[j] <= dla[j-1];
                    dlb[j] <= dlb[j-1];
                end
            end
        end

        assign a_out[i] = dla[i];
        assign b_out[i] = dlb[i];
    end

    assign a1 = a_out[0];
    assign a2 = a_out[1];
    assign a3 = a_out[2];
    assign a4 = a_out[3];
    assign b1 = b_out[0];
    assign b2 = b_out[1];
    assign b3 = b_out[2];
    assign b4 = b_out[3];
endmodule
